vend_param: RTL and testbench
=============================

VEND_PARAM -- requirements
Module: vend_param

Interface
REQ-001 SHALL have parameter PRICE, default 150, meaning item price in yen; must be a nonzero multiple of 10.
REQ-002 SHALL have parameter CREDIT_W, default 6, meaning credit register width in 10-yen units (max credit (2^CREDIT_W-1)*10 yen).
REQ-003 SHALL have port ck  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port res  input  1  synchronous, active-high reset, sampled on rising edge of ck.
REQ-005 SHALL have port c0  input  1  50-yen coin strobe, one cycle per coin.
REQ-006 SHALL have port c1  input  1  100-yen coin strobe, one cycle per coin.
REQ-007 SHALL have port c2  input  1  10-yen coin strobe, one cycle per coin.
REQ-008 SHALL have port cancel  input  1  refund request (present only with VEND_CANCEL_EN).
REQ-009 SHALL have port y0  output  1  vend pulse, one cycle per item.
REQ-010 SHALL have port y1  output  1  dispense one 50-yen change coin this cycle.
REQ-011 SHALL have port y2  output  1  dispense one 10-yen change coin this cycle.
REQ-012 SHALL have port rej  output  1  coin rejected this cycle (returned to user).
REQ-013 SHALL have port credit  output  CREDIT_W  current credit in 10-yen units.
REQ-014 SHALL have port busy  output  1  high in VEND and CHANGE states.

Function
REQ-015 SHALL implement FSM states COLLECT, VEND, CHANGE; all outputs Moore-decoded from state and credit register.
REQ-016 In COLLECT, exactly one of c0/c1/c2 high at an edge SHALL add 5/10/1 to credit at that edge.
REQ-017 Two or more coin strobes at one edge SHALL leave credit unchanged and assert rej for the following cycle.
REQ-018 A coin that would push credit above 2^CREDIT_W-1 SHALL be rejected (rej one cycle, credit unchanged).
REQ-019 If updated credit >= PRICE/10, FSM SHALL enter VEND at the same edge; y0=1 for exactly that one cycle.
REQ-020 On the edge leaving VEND, credit SHALL decrease by PRICE/10; next state CHANGE if remainder >0, else COLLECT.
REQ-021 In CHANGE, y1=1 when credit>=5, else y2=1; each edge subtracts 5 or 1 respectively; exactly one of y1/y2 high per cycle.
REQ-022 CHANGE SHALL return to COLLECT at the edge where credit reaches 0; no y1/y2 in that next cycle.
REQ-023 Coins arriving in VEND or CHANGE SHALL be rejected (rej next cycle), credit unaffected.
REQ-024 Overpayment on the completing coin (e.g. 100 on 100 credit, PRICE 150) SHALL vend then return change minimal-coin (50s before 10s).

Reset
REQ-025 res=1 at an edge SHALL force state COLLECT, credit=0, y0=y1=y2=rej=busy=0 from the next cycle, overriding any coin or cancel, including mid-CHANGE.

Configuration
REQ-026 Macro VEND_CANCEL_EN defined: cancel port present; cancel=1 in COLLECT with credit>0 SHALL enter CHANGE without vend, refunding full credit via REQ-021.
REQ-027 With VEND_CANCEL_EN: cancel and coin at same edge SHALL reject the coin and perform the refund; cancel with credit 0 or outside COLLECT SHALL be ignored.
REQ-028 Macro VEND_CANCEL_EN undefined: no cancel port, no refund path; all other behaviour identical.

Structure
REQ-029 Shared package vend_pkg SHALL hold the state enum typedef and coin-value constants (COIN10=1, COIN50=5, COIN100=10).
REQ-030 Change dispensing SHALL be a sub-module vend_change (credit in, y1/y2 select and decrement out); coin acceptance and FSM in top.

Verification (PRICE=150, CREDIT_W=6 unless stated)
REQ-031 c0,c0,c0 pulses -> credit 5,10,15; y0 one cycle; credit 0; no y1/y2; back to COLLECT.
REQ-032 c1,c1 -> credit 20; y0 one cycle; credit 5; y1 one cycle; credit 0; y2 never.
REQ-033 c0 and c1 same edge -> rej one cycle, credit stays 0; then c1 during CHANGE of a later vend -> rej, change sequence unaltered.
REQ-034 VEND_CANCEL_EN: c0,c2 (credit 6) then cancel -> y1 one cycle, y2 one cycle, y0 never, credit 0.
REQ-035 CREDIT_W=4, PRICE=200: c1 then c0 (credit 15) then c2 -> rej, credit stays 15.
REQ-036 res asserted during CHANGE after c1,c1 -> next cycle y1=y2=busy=0, credit 0, state COLLECT.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared FSM state type and coin values for the vending machine
// Contents:
//   state_t : COLLECT / VEND / CHANGE controller states
//   COIN10, COIN50, COIN100 : coin values in 10-yen credit units
package vend_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2
  } state_t;

  localparam int COIN10  = 1;
  localparam int COIN50  = 5;
  localparam int COIN100 = 10;

endpackage

// File: rtl/vend_change.sv
// rtl/vend_change.sv - change-coin selector, one coin per cycle, 50s before 10s
// Ports:
//   active : controller is in CHANGE (outputs are zero otherwise)
//   credit : remaining credit in 10-yen units
//   y1     : dispense one 50-yen coin this cycle
//   y2     : dispense one 10-yen coin this cycle
//   dec    : amount to subtract from credit at the next edge
module vend_change
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                active,
  input  logic [CREDIT_W-1:0] credit,
  output logic                y1,
  output logic                y2,
  output logic [CREDIT_W-1:0] dec
);

  // Compare in a widened domain so narrow credit registers still compile cleanly.
  localparam logic [CREDIT_W+3:0] C50_W = (CREDIT_W + 4)'(COIN50);

  logic big;
  assign big = ({4'b0, credit} >= C50_W);

  always_comb begin
    y1  = 1'b0;
    y2  = 1'b0;
    dec = '0;
    if (active) begin
      if (big) begin
        y1  = 1'b1;
        dec = CREDIT_W'(COIN50);
      end else begin
        y2  = 1'b1;
        dec = CREDIT_W'(COIN10);
      end
    end
  end

endmodule

// File: rtl/vend_param.sv
// rtl/vend_param.sv - parameterised coin-operated vending controller
// Optional feature: VEND_CANCEL_EN adds the cancel port and refund path.
// Parameters:
//   PRICE    : item price in yen (nonzero multiple of 10)
//   CREDIT_W : credit register width in 10-yen units
// Ports:
//   ck     : clock, rising edge
//   res    : synchronous active-high reset
//   c0     : 50-yen coin strobe
//   c1     : 100-yen coin strobe
//   c2     : 10-yen coin strobe
//   cancel : refund request (VEND_CANCEL_EN only)
//   y0     : vend pulse
//   y1     : 50-yen change coin
//   y2     : 10-yen change coin
//   rej    : coin returned this cycle
//   credit : current credit in 10-yen units
//   busy   : high in VEND and CHANGE
module vend_param
  import vend_pkg::*;
#(
  parameter int PRICE    = 150,
  parameter int CREDIT_W = 6
) (
  input  logic                ck,
  input  logic                res,
  input  logic                c0,
  input  logic                c1,
  input  logic                c2,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                y0,
  output logic                y1,
  output logic                y2,
  output logic                rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  // Coin sums are formed with headroom so overflow past the register is visible.
  localparam int SW = CREDIT_W + 5;
  localparam logic [SW-1:0]       PRICE_W    = SW'(PRICE / 10);
  localparam logic [SW-1:0]       CREDIT_MAX = SW'((1 << CREDIT_W) - 1);
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE / 10);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic                rej_q, rej_n;
  logic [1:0]          coin_cnt;
  logic                coin_any;
  logic                cancel_req;
  logic [SW-1:0]       coin_val;
  logic [SW-1:0]       sum;
  logic                chg_y1, chg_y2;
  logic [CREDIT_W-1:0] chg_dec;

`ifdef VEND_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  assign coin_cnt = {1'b0, c0} + {1'b0, c1} + {1'b0, c2};
  assign coin_any = (coin_cnt != 2'd0);

  // Value of the single coin; only meaningful when coin_cnt == 1.
  always_comb begin
    coin_val = '0;
    if (c0)      coin_val = SW'(COIN50);
    else if (c1) coin_val = SW'(COIN100);
    else if (c2) coin_val = SW'(COIN10);
  end

  assign sum = SW'(credit_q) + coin_val;

  vend_change #(
    .CREDIT_W(CREDIT_W)
  ) u_change (
    .active(state == ST_CHANGE),
    .credit(credit_q),
    .y1    (chg_y1),
    .y2    (chg_y2),
    .dec   (chg_dec)
  );

  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    rej_n    = 1'b0;
    case (state)
      ST_COLLECT: begin
        // A refund takes priority over a coin arriving at the same edge.
        if (cancel_req && (credit_q != '0)) begin
          state_n = ST_CHANGE;
          rej_n   = coin_any;
        end else if (coin_cnt > 2'd1) begin
          rej_n = 1'b1;
        end else if (coin_cnt == 2'd1) begin
          if (sum > CREDIT_MAX) begin
            rej_n = 1'b1;
          end else begin
            credit_n = sum[CREDIT_W-1:0];
            if (sum >= PRICE_W) state_n = ST_VEND;
          end
        end
      end
      ST_VEND: begin
        rej_n    = coin_any;
        credit_n = credit_q - PRICE_C;
        state_n  = (credit_n != '0) ? ST_CHANGE : ST_COLLECT;
      end
      ST_CHANGE: begin
        rej_n    = coin_any;
        credit_n = credit_q - chg_dec;
        if (credit_n == '0) state_n = ST_COLLECT;
      end
      default: begin
        state_n  = ST_COLLECT;
        credit_n = '0;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (res) begin
      state    <= ST_COLLECT;
      credit_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      rej_q    <= rej_n;
    end
  end

  assign y0     = (state == ST_VEND);
  assign y1     = chg_y1;
  assign y2     = chg_y2;
  assign rej    = rej_q;
  assign credit = credit_q;
  assign busy   = (state != ST_COLLECT);

endmodule

// File: tb/tb_vend_param.sv
// tb/tb_vend_param.sv - directed self-checking bench for vend_param
module tb_vend_param;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic res = 1'b1;
  logic c0 = 1'b0, c1 = 1'b0, c2 = 1'b0;
  logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0;
`ifdef VEND_CANCEL_EN
  logic cancel = 1'b0, cancel_b = 1'b0;
`endif

  logic       y0, y1, y2, rej, busy;
  logic [5:0] credit;
  logic       by0, by1, by2, brej, bbusy;
  logic [3:0] bcredit;

  vend_param #(.PRICE(150), .CREDIT_W(6)) dut_a (
    .ck(ck), .res(res), .c0(c0), .c1(c1), .c2(c2),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .y0(y0), .y1(y1), .y2(y2), .rej(rej), .credit(credit), .busy(busy)
  );

  vend_param #(.PRICE(200), .CREDIT_W(4)) dut_b (
    .ck(ck), .res(res), .c0(b0), .c1(b1), .c2(b2),
`ifdef VEND_CANCEL_EN
    .cancel(cancel_b),
`endif
    .y0(by0), .y1(by1), .y2(by2), .rej(brej), .credit(bcredit), .busy(bbusy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (y0 y1 y2 rej busy|credit)", tag, got, exp);
    end
  endtask

  function automatic int pk(input logic a, b, c, d, e, input int cr);
    return (int'({a, b, c, d, e}) << 8) | cr;
  endfunction

  function automatic int obs_a();
    return pk(y0, y1, y2, rej, busy, int'(credit));
  endfunction

  function automatic int obs_b();
    return pk(by0, by1, by2, brej, bbusy, int'(bcredit));
  endfunction

  // Drive strobes for one edge on dut_a; outputs are settled when this returns.
  task automatic cyc(input logic a, b, c);
    @(negedge ck);
    c0 = a; c1 = b; c2 = c;
    @(posedge ck);
    #1;
    c0 = 1'b0; c1 = 1'b0; c2 = 1'b0;
  endtask

  task automatic cyc_b(input logic a, b, c);
    @(negedge ck);
    b0 = a; b1 = b; b2 = c;
    @(posedge ck);
    #1;
    b0 = 1'b0; b1 = 1'b0; b2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ck);
    res = 1'b1;
    @(posedge ck);
    #1;
    res = 1'b0;
  endtask

  initial begin
    do_reset();
    check("reset_a", obs_a(), pk(0, 0, 0, 0, 0, 0));
    check("reset_b", obs_b(), pk(0, 0, 0, 0, 0, 0));

    // Three 50-yen coins: exact price, no change
    cyc(1, 0, 0); check("c0_1", obs_a(), pk(0, 0, 0, 0, 0, 5));
    cyc(1, 0, 0); check("c0_2", obs_a(), pk(0, 0, 0, 0, 0, 10));
    cyc(1, 0, 0); check("c0_vend", obs_a(), pk(1, 0, 0, 0, 1, 15));
    cyc(0, 0, 0); check("c0_done", obs_a(), pk(0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0); check("c0_idle", obs_a(), pk(0, 0, 0, 0, 0, 0));

    // Two 100-yen coins: vend then one 50-yen change coin
    cyc(0, 1, 0); check("c1_1", obs_a(), pk(0, 0, 0, 0, 0, 10));
    cyc(0, 1, 0); check("c1_vend", obs_a(), pk(1, 0, 0, 0, 1, 20));
    cyc(0, 0, 0); check("c1_chg50", obs_a(), pk(0, 1, 0, 0, 1, 5));
    cyc(0, 0, 0); check("c1_done", obs_a(), pk(0, 0, 0, 0, 0, 0));

    // Simultaneous strobes rejected
    cyc(1, 1, 0); check("dual_rej", obs_a(), pk(0, 0, 0, 1, 0, 0));
    cyc(0, 0, 0); check("dual_clr", obs_a(), pk(0, 0, 0, 0, 0, 0));
    cyc(1, 1, 1); check("triple_rej", obs_a(), pk(0, 0, 0, 1, 0, 0));

    // Credit 14 then 50 -> 19: vend, 4 units change in 10s; coins in VEND/CHANGE rejected
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    check("acc_14", obs_a(), pk(0, 0, 0, 0, 0, 14));
    cyc(1, 0, 0); check("v19_vend", obs_a(), pk(1, 0, 0, 0, 1, 19));
    cyc(0, 0, 1); check("v19_rej_vend", obs_a(), pk(0, 0, 1, 1, 1, 4));
    cyc(0, 1, 0); check("v19_rej_chg", obs_a(), pk(0, 0, 1, 1, 1, 3));
    cyc(0, 0, 0); check("v19_chg2", obs_a(), pk(0, 0, 1, 0, 1, 2));
    cyc(0, 0, 0); check("v19_chg1", obs_a(), pk(0, 0, 1, 0, 1, 1));
    cyc(0, 0, 0); check("v19_done", obs_a(), pk(0, 0, 0, 0, 0, 0));

    // Reset mid-CHANGE overrides a coin at the same edge
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0); check("pre_reset_chg", obs_a(), pk(0, 1, 0, 0, 1, 5));
    @(negedge ck);
    res = 1'b1; c1 = 1'b1;
    @(posedge ck);
    #1;
    res = 1'b0; c1 = 1'b0;
    check("reset_mid_chg", obs_a(), pk(0, 0, 0, 0, 0, 0));
    cyc(0, 0, 0); check("after_reset", obs_a(), pk(0, 0, 0, 0, 0, 0));

    // Narrow build: CREDIT_W=4, PRICE=200, overflow rejection
    cyc_b(0, 1, 0); check("b_c1", obs_b(), pk(0, 0, 0, 0, 0, 10));
    cyc_b(1, 0, 0); check("b_c0", obs_b(), pk(0, 0, 0, 0, 0, 15));
    cyc_b(0, 0, 1); check("b_ovf10", obs_b(), pk(0, 0, 0, 1, 0, 15));
    cyc_b(0, 0, 0); check("b_hold", obs_b(), pk(0, 0, 0, 0, 0, 15));
    cyc_b(1, 0, 0); check("b_ovf50", obs_b(), pk(0, 0, 0, 1, 0, 15));

`ifdef VEND_CANCEL_EN
    // Cancel with zero credit is ignored; the coin is accepted
    @(negedge ck); cancel = 1'b1; c2 = 1'b1;
    @(posedge ck); #1; cancel = 1'b0; c2 = 1'b0;
    check("cancel_zero", obs_a(), pk(0, 0, 0, 0, 0, 1));
    cyc(1, 0, 0); check("cancel_acc6", obs_a(), pk(0, 0, 0, 0, 0, 6));
    // Cancel with a coin: coin rejected, refund starts
    @(negedge ck); cancel = 1'b1; c1 = 1'b1;
    @(posedge ck); #1; cancel = 1'b0; c1 = 1'b0;
    check("cancel_y1", obs_a(), pk(0, 1, 0, 1, 1, 6));
    cyc(0, 0, 0); check("cancel_y2", obs_a(), pk(0, 0, 1, 0, 1, 1));
    cyc(0, 0, 0); check("cancel_done", obs_a(), pk(0, 0, 0, 0, 0, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
